// File: rtl/saturn_kbd_pkg.sv
// Shared constants, FSM state type and packet snapshot layout for the Saturn keyboard port.
package saturn_kbd_pkg;

    localparam logic [3:0] NIB_ID0  = 4'h3;
    localparam logic [3:0] NIB_ID1  = 4'h4;
    localparam logic [3:0] EV_MAKE  = 4'hE;
    localparam logic [3:0] EV_BREAK = 4'h7;
    localparam logic [3:0] EV_NONE  = 4'h6;
    localparam logic [3:0] NIB_TRL0 = 4'h0;
    localparam logic [3:0] NIB_TRL1 = 4'h1;
    localparam int         PKT_LEN  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ACK   = 2'd2,
        ST_WAIT  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [3:0] dpad;
        logic [3:0] start_abc;
        logic [3:0] rxyz;
        logic [3:0] lxxx;
        logic [3:0] led;
        logic [3:0] ev;
        logic [7:0] sc;
        logic       had_ev;
    } snap_t;

    // Indices past the packet end read as zero so over-reads are harmless.
    function automatic logic [3:0] pkt_nibble(input snap_t s, input logic [3:0] idx);
        logic [3:0] n;
        case (idx)
            4'd0:    n = NIB_ID0;
            4'd1:    n = NIB_ID1;
            4'd2:    n = s.dpad;
            4'd3:    n = s.start_abc;
            4'd4:    n = s.rxyz;
            4'd5:    n = s.lxxx;
            4'd6:    n = s.led;
            4'd7:    n = s.ev;
            4'd8:    n = s.sc[7:4];
            4'd9:    n = s.sc[3:0];
            4'd10:   n = NIB_TRL0;
            4'd11:   n = NIB_TRL1;
            default: n = 4'h0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sat_pin_sync.sv
// Two-flop synchroniser for an asynchronous pad input with single-cycle rise/fall pulses.
module sat_pin_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = pin;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/saturn_kbd_port_tx.sv
// Saturn keyboard packet transmitter over the TH/TR/TL handshake.
// Define SAT_KBD_TIMEOUT_EN to abort a packet after TIMEOUT_CYC idle-TR cycles in WAIT.
module saturn_kbd_port_tx
    import saturn_kbd_pkg::*;
#(
`ifdef SAT_KBD_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 65535,
`endif
    parameter int ACK_DELAY   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] nib_dpad,
    input  logic [3:0] nib_start_abc,
    input  logic [3:0] nib_rxyz,
    input  logic [3:0] nib_lxxx,
    input  logic [2:0] led,
    input  logic       ev_valid,
    input  logic       ev_make,
    input  logic [7:0] ev_sc,
    output logic       ev_pop,
    input  logic       pad_th,
    input  logic       pad_tr,
    output logic       pad_tl,
    output logic [3:0] pad_d
);

    localparam logic [3:0] ACK_LAST = 4'(ACK_DELAY - 1);
    localparam logic [3:0] IDX_LAST = 4'(PKT_LEN - 1);
    localparam logic [3:0] IDX_OVER = 4'(PKT_LEN);

    logic th_rise, th_fall, tr_rise, tr_fall, tr_edge;

    sat_pin_sync #(.RST_VAL(1'b1)) u_th_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (pad_th),
        .rise  (th_rise),
        .fall  (th_fall)
    );

    sat_pin_sync #(.RST_VAL(1'b1)) u_tr_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (pad_tr),
        .rise  (tr_rise),
        .fall  (tr_fall)
    );

    assign tr_edge = tr_rise | tr_fall;

    tx_state_t  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       tl_q, tl_d;
    snap_t      snap_q, snap_d;
    snap_t      snap_now;

`ifdef SAT_KBD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC);
    logic [15:0] to_q, to_d;
`endif

    always_comb begin
        snap_now.dpad      = nib_dpad;
        snap_now.start_abc = nib_start_abc;
        snap_now.rxyz      = nib_rxyz;
        snap_now.lxxx      = nib_lxxx;
        snap_now.led       = {1'b0, led[0], led[1], led[2]};
        snap_now.ev        = !ev_valid ? EV_NONE : (ev_make ? EV_MAKE : EV_BREAK);
        snap_now.sc        = ev_valid ? ev_sc : 8'h00;
        snap_now.had_ev    = ev_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            tl_q    <= 1'b1;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tl_q    <= tl_d;
            snap_q  <= snap_d;
        end
    end

`ifdef SAT_KBD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) to_q <= 16'd0;
        else       to_q <= to_d;
    end
`endif

    // TH rising is checked first in every active state so it beats a same-cycle TR edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tl_d    = tl_q;
        snap_d  = snap_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (th_fall) begin
                        snap_d  = snap_now;
                        idx_d   = 4'd0;
                        cnt_d   = 4'd0;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (th_rise) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == ACK_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_ACK: begin
                    if (th_rise) begin
                        state_d = ST_IDLE;
                    end else begin
                        tl_d    = ~tl_q;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (th_rise) begin
                        state_d = ST_IDLE;
                    end else if (tr_edge) begin
                        idx_d   = (idx_q < IDX_LAST) ? idx_q + 4'd1 : IDX_OVER;
                        cnt_d   = 4'd0;
                        state_d = ST_SETUP;
                    end
`ifdef SAT_KBD_TIMEOUT_EN
                    else if (to_q == TO_LAST) begin
                        state_d = ST_IDLE;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) begin
            tl_d = 1'b1;
        end
    end

`ifdef SAT_KBD_TIMEOUT_EN
    always_comb begin
        to_d = to_q + 16'd1;
        if (state_q != ST_WAIT || state_d != state_q || tr_edge) begin
            to_d = 16'd0;
        end
    end
`endif

    always_comb begin
        pad_tl = tl_q;
        pad_d  = (state_q == ST_IDLE) ? NIB_TRL1 : pkt_nibble(snap_q, idx_q);
        ev_pop = enable && (state_q == ST_ACK) && !th_rise &&
                 (idx_q == IDX_LAST) && snap_q.had_ev;
    end

endmodule
